// File: rtl/score_pkg.sv
// Shared constants, types and BCD helper for the score display.
package score_pkg;

    localparam int NUM_DIGITS   = 8;
    localparam int SCORE_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low cathode patterns, bit 0 = CA ... bit 6 = CG
    localparam logic [6:0] SEG_DIGITS [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef logic [15:0] bcd16_t;

    // Adds a single BCD digit to a 4-digit BCD word, clamping at 9999
    function automatic bcd16_t bcd_add_sat(input bcd16_t a, input logic [3:0] inc);
        bcd16_t     r;
        logic [4:0] sum;
        logic       c;
        r = 16'h0000;
        c = 1'b0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            sum = {1'b0, a[i*4 +: 4]} + ((i == 0) ? {1'b0, inc} : 5'd0) + {4'd0, c};
            if (sum > 5'd9) begin
                r[i*4 +: 4] = 4'(sum - 5'd10);
                c           = 1'b1;
            end else begin
                r[i*4 +: 4] = sum[3:0];
                c           = 1'b0;
            end
        end
        if (c) begin
            r = 16'h9999;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 and blank give SEG_BLANK.
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_DIGITS[0];
                4'd1:    seg = SEG_DIGITS[1];
                4'd2:    seg = SEG_DIGITS[2];
                4'd3:    seg = SEG_DIGITS[3];
                4'd4:    seg = SEG_DIGITS[4];
                4'd5:    seg = SEG_DIGITS[5];
                4'd6:    seg = SEG_DIGITS[6];
                4'd7:    seg = SEG_DIGITS[7];
                4'd8:    seg = SEG_DIGITS[8];
                4'd9:    seg = SEG_DIGITS[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Saturating BCD score tracker and 8-digit multiplexed seven-segment driver.
// Optional high-score register and display enabled by SCORE_HIGH_SCORE_EN.
module score_display
    import score_pkg::*;
#(
    parameter int unsigned HIT_POINTS  = 1,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        alien_hit,
    input  logic        game_over,
    input  logic        game_start,
    input  logic        pause,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_score_bcd,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       HIT_INC  = 4'(HIT_POINTS);

    logic             hit_q, hit_d;
    logic             start_q, start_d;
    bcd16_t           score_q, score_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             hit_evt_s, start_evt_s;
    logic [3:0]       sel_digit_s;
    logic             sel_blank_s;
    logic [6:0]       dec_seg_s;

`ifdef SCORE_HIGH_SCORE_EN
    logic   go_q, go_d;
    bcd16_t hi_q, hi_d;

    // High score latches on the game_over rise when beaten
    always_comb begin
        go_d = game_over;
        hi_d = hi_q;
        if (game_over && !go_q && (score_q > hi_q)) begin
            hi_d = score_q;
        end else begin
            hi_d = hi_q;
        end
    end

    // High-score registers
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            go_q <= 1'b0;
            hi_q <= 16'h0000;
        end else begin
            go_q <= go_d;
            hi_q <= hi_d;
        end
    end

    assign hi_score_bcd = hi_q;
`else
    assign hi_score_bcd = 16'h0000;
`endif

    // Edge detection and score update; a start clear beats a same-cycle hit
    always_comb begin
        hit_d       = alien_hit;
        start_d     = game_start;
        hit_evt_s   = alien_hit & ~hit_q;
        start_evt_s = game_start & ~start_q;
        score_d     = score_q;
        if (start_evt_s) begin
            score_d = 16'h0000;
        end else if (hit_evt_s && !pause && !game_over && game_start) begin
            score_d = bcd_add_sat(score_q, HIT_INC);
        end else begin
            score_d = score_q;
        end
    end

    // Digit source for the slot currently being scanned
    always_comb begin
        sel_digit_s = 4'd0;
        sel_blank_s = 1'b0;
        if (digit_idx_q < 3'd4) begin
            sel_digit_s = score_q[{digit_idx_q[1:0], 2'b00} +: 4];
        end else begin
`ifdef SCORE_HIGH_SCORE_EN
            sel_digit_s = hi_q[{digit_idx_q[1:0], 2'b00} +: 4];
`else
            sel_blank_s = 1'b1;
`endif
        end
    end

    seg7_decode u_dec (
        .digit (sel_digit_s),
        .blank (sel_blank_s),
        .seg   (dec_seg_s)
    );

    // Scan counter; anode and cathodes load together with the slot advance
    always_comb begin
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        digit_idx_d = digit_idx_q;
        an_d        = an_q;
        seg_d       = seg_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + 3'd1;
            an_d        = ~(8'b0000_0001 << digit_idx_q);
            seg_d       = dec_seg_s;
        end else begin
            digit_idx_d = digit_idx_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hit_q       <= 1'b0;
            start_q     <= 1'b0;
            score_q     <= 16'h0000;
            div_cnt_q   <= '0;
            digit_idx_q <= 3'd0;
            an_q        <= 8'hFF;
            seg_q       <= SEG_BLANK;
        end else begin
            hit_q       <= hit_d;
            start_q     <= start_d;
            score_q     <= score_d;
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign score_bcd = score_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: HIT_POINTS=1 and HIT_POINTS=9 instances, REFRESH_DIV=4.
module tb_score_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, alien_hit, game_over, game_start, pause;
    logic [15:0] score1, hi1, score9, hi9;
    logic [7:0]  an1, an9;
    logic [6:0]  seg1, seg9;
    logic        dp1, dp9;

    always #5 clk = ~clk;

    score_display #(.HIT_POINTS(1), .REFRESH_DIV(DIV)) dut (
        .clk_100MHz(clk), .reset(reset), .alien_hit(alien_hit), .game_over(game_over),
        .game_start(game_start), .pause(pause), .score_bcd(score1), .hi_score_bcd(hi1),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    score_display #(.HIT_POINTS(9), .REFRESH_DIV(DIV)) dut9 (
        .clk_100MHz(clk), .reset(reset), .alien_hit(alien_hit), .game_over(game_over),
        .game_start(game_start), .pause(pause), .score_bcd(score9), .hi_score_bcd(hi9),
        .an(an9), .seg(seg9), .dp(dp9)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int          m_s1, m_s9, m_hi, m_div, m_idx;
    logic [15:0] m_disp;
    bit          m_hit_p, m_start_p, m_go_p;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int dec_digit(input int v, input int pos);
        int p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0: return {16'h0000, score1};
            1: return {16'h0000, score9};
            2: return {16'h0000, an1, seg1, dp1};
            3: return {16'h0000, hi1};
            default: return 32'h0;
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s9 = 0; m_hi = 0; m_div = 0; m_idx = 0;
        m_hit_p = 1'b0; m_start_p = 1'b0; m_go_p = 1'b0;
        m_disp = {8'hFF, 7'h7F, 1'b1};
    endtask

    task automatic expect_state(input string tag);
        push({tag, ".score1"}, 0, {16'h0, to_bcd(m_s1)});
        push({tag, ".score9"}, 1, {16'h0, to_bcd(m_s9)});
        push({tag, ".hi"}, 3, {16'h0, to_bcd(m_hi)});
        drain();
    endtask

    // Advance one clock; the model sees the same inputs the DUT samples at this edge
    task automatic tick(input bit chk_disp = 1'b0);
        logic [6:0] s;
        bit         hit_evt, start_evt, go_evt;
        if (m_div == DIV - 1) begin
            m_div = 0;
            if (m_idx < 4) s = pat(dec_digit(m_s1, m_idx));
`ifdef SCORE_HIGH_SCORE_EN
            else s = pat(dec_digit(m_hi, m_idx - 4));
`else
            else s = 7'h7F;
`endif
            m_disp = {~(8'd1 << m_idx), s, 1'b1};
            m_idx  = (m_idx + 1) % 8;
        end else begin
            m_div++;
        end
        hit_evt   = alien_hit && !m_hit_p;
        start_evt = game_start && !m_start_p;
        go_evt    = game_over && !m_go_p;
`ifdef SCORE_HIGH_SCORE_EN
        if (go_evt && m_s1 > m_hi) m_hi = m_s1;
`endif
        if (start_evt) begin
            m_s1 = 0;
            m_s9 = 0;
        end else if (hit_evt && !pause && !game_over && game_start) begin
            m_s1 = (m_s1 + 1 > 9999) ? 9999 : m_s1 + 1;
            m_s9 = (m_s9 + 9 > 9999) ? 9999 : m_s9 + 9;
        end
        m_hit_p   = alien_hit;
        m_start_p = game_start;
        m_go_p    = game_over;
        if (chk_disp) push($sformatf("disp.idx%0d", m_idx), 2, {16'h0, m_disp});
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            alien_hit = 1'b1; tick();
            alien_hit = 1'b0; tick();
        end
    endtask

    task automatic new_game();
        game_start = 1'b0; tick();
        game_start = 1'b1; tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; alien_hit = 1'b0; game_over = 1'b0; game_start = 1'b0; pause = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_state("reset");
        push("reset.disp", 2, {16'h0, 8'hFF, 7'h7F, 1'b1});
        drain();
        reset = 1'b0;

        game_start = 1'b1; tick();
        expect_state("start");
        for (int i = 0; i < 3; i++) begin
            alien_hit = 1'b1; tick();
            expect_state($sformatf("hit%0d", i));
            alien_hit = 1'b0; tick();
        end
        check_val("three_hits", {16'h0, score1}, 32'h0003);

        alien_hit = 1'b1;
        repeat (50) tick();
        alien_hit = 1'b0; tick();
        expect_state("held");
        check_val("held_once", {16'h0, score1}, 32'h0004);

        pause = 1'b1; hits(1); pause = 1'b0;
        expect_state("paused");
        game_over = 1'b1; hits(1);
        expect_state("over");
        check_val("over_frozen", {16'h0, score1}, 32'h0004);
        game_over = 1'b0; tick();

        game_start = 1'b0; tick();
        game_start = 1'b1; alien_hit = 1'b1; tick();
        expect_state("start_and_hit");
        check_val("start_wins", {16'h0, score1}, 32'h0000);
        alien_hit = 1'b0; tick();

        hits(999);
        check_val("to_0999", {16'h0, score1}, 32'h0999);
        hits(1);
        expect_state("carry");
        check_val("to_1000", {16'h0, score1}, 32'h1000);
        check_val("nine_9000", {16'h0, score9}, 32'h9000);
        hits(8998);
        check_val("to_9998", {16'h0, score1}, 32'h9998);
        hits(1);
        check_val("to_9999", {16'h0, score1}, 32'h9999);
        hits(1);
        expect_state("sat");
        check_val("sat_hold", {16'h0, score1}, 32'h9999);
        check_val("nine_sat", {16'h0, score9}, 32'h9999);

        new_game();
        hits(42);
        game_over = 1'b1; tick();
        expect_state("hi42");
`ifdef SCORE_HIGH_SCORE_EN
        check_val("hi_0042", {16'h0, hi1}, 32'h0042);
`else
        check_val("hi_zero", {16'h0, hi1}, 32'h0000);
`endif
        game_over = 1'b0; tick();
        new_game();
        hits(10);
        game_over = 1'b1; tick();
        expect_state("hi_keep");
`ifdef SCORE_HIGH_SCORE_EN
        check_val("hi_stays", {16'h0, hi1}, 32'h0042);
`else
        check_val("hi_still_zero", {16'h0, hi1}, 32'h0000);
`endif
        game_over = 1'b0; tick();

        new_game();
        hits(1234);
        check_val("to_1234", {16'h0, score1}, 32'h1234);
        repeat (40) tick(1'b1);

        new_game();
        hits(777);
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("async.score", {16'h0, score1}, 32'h0000);
        check_val("async.hi", {16'h0, hi1}, 32'h0000);
        check_val("async.disp", {16'h0, an1, seg1, dp1}, {16'h0, 8'hFF, 7'h7F, 1'b1});
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        hits(2);
        repeat (8) tick(1'b1);
        expect_state("resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
